// File: rtl/store_bcd_monitor_pkg.sv
// Shared types and elaboration helpers for the store BCD monitor.
package store_mon_pkg;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} mon_state_t;

   // True when DIGITS decimal digits can hold the largest BITS-wide binary value.
   function automatic bit bcd_digits_ok(input int bits, input int digits);
      longint unsigned max_bin;
      longint unsigned lim;
      max_bin = (64'd1 << bits) - 64'd1;
      lim     = 64'd1;
      for (int i = 0; i < digits; i++) lim = lim * 64'd10;
      return lim > max_bin;
   endfunction

endpackage

// File: rtl/store_bcd_monitor_if.sv
// Store port from the core plus the BCD/status results presented to the display side.
interface store_bcd_monitor_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_DIGITS = 4,
   parameter int VAL_DIGITS  = 4,
   parameter int CNT_W       = 16
);
   logic                     mem_write;
   logic [DATA_WIDTH-1:0]    data_addr;
   logic [DATA_WIDTH-1:0]    write_data;
   logic [4*ADDR_DIGITS-1:0] addr_bcd;
   logic [4*VAL_DIGITS-1:0]  val_bcd;
   logic                     upd_pulse;
   logic                     busy;
   logic                     pend_full;
   logic [CNT_W-1:0]         store_cnt;
   logic [CNT_W-1:0]         overrun_cnt;

   modport master (
      output mem_write, data_addr, write_data,
      input  addr_bcd, val_bcd, upd_pulse, busy, pend_full, store_cnt, overrun_cnt
   );

   modport slave (
      input  mem_write, data_addr, write_data,
      output addr_bcd, val_bcd, upd_pulse, busy, pend_full, store_cnt, overrun_cnt
   );
endinterface

// File: rtl/store_bcd_monitor_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift per step, BITS steps per conversion.
module bin2bcd_seq #(
   parameter int BITS   = 10,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [BITS-1:0]     bin,
   input  logic                step,
   output logic [4*DIGITS-1:0] bcd
);
   logic [BITS-1:0]     bin_q, bin_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      adj   = bcd_q;
      bin_d = bin_q;
      bcd_d = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      if (load) begin
         bin_d = bin;
         bcd_d = '0;
      end else if (step) begin
         bcd_d = {adj[4*DIGITS-2:0], bin_q[BITS-1]};
         bin_d = bin_q << 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q <= '0;
         bcd_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/store_bcd_monitor.sv
// Watches core stores, converts address/value to BCD for the 7-segment decoders, buffers one store while busy.
module store_bcd_monitor
   import store_mon_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_BITS   = 10,
   parameter int VAL_BITS    = 10,
   parameter int ADDR_DIGITS = 4,
   parameter int VAL_DIGITS  = 4,
   parameter bit FILTER_EN   = 1'b0,
   parameter int WATCH_ADDR  = 96,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   store_bcd_monitor_if.slave  bus
);
   localparam int N  = (ADDR_BITS > VAL_BITS) ? ADDR_BITS : VAL_BITS;
   localparam int CW = $clog2(N + 1);

   if (!bcd_digits_ok(ADDR_BITS, ADDR_DIGITS)) begin : g_addr_digits_chk
      $error("ADDR_DIGITS too small for ADDR_BITS");
   end
   if (!bcd_digits_ok(VAL_BITS, VAL_DIGITS)) begin : g_val_digits_chk
      $error("VAL_DIGITS too small for VAL_BITS");
   end

   mon_state_t               state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     pend_full_q, pend_full_d;
   logic [N-1:0]             pend_addr_q, pend_addr_d, pend_val_q, pend_val_d;
   logic [4*ADDR_DIGITS-1:0] addr_bcd_q, eng_addr_bcd;
   logic [4*VAL_DIGITS-1:0]  val_bcd_q, eng_val_bcd;
   logic                     upd_q;
   logic [CNT_W-1:0]         store_cnt_q, store_cnt_d, overrun_cnt_q, overrun_cnt_d;

   logic         acc, addr_match, eng_load, eng_step, out_we, consume, overrun_inc;
   logic [N-1:0] cap_addr, cap_val, ld_addr, ld_val;

   assign addr_match = bus.data_addr[ADDR_BITS-1:0] == ADDR_BITS'(WATCH_ADDR);
   assign acc        = bus.mem_write && (!FILTER_EN || addr_match);
   assign cap_addr   = N'(bus.data_addr[ADDR_BITS-1:0]);
   assign cap_val    = N'(bus.write_data[VAL_BITS-1:0]);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      eng_load    = 1'b0;
      eng_step    = 1'b0;
      out_we      = 1'b0;
      consume     = 1'b0;
      ld_addr     = cap_addr;
      ld_val      = cap_val;
      unique case (state_q)
         S_IDLE: if (acc) begin
            eng_load = 1'b1;
            cnt_d    = '0;
            state_d  = S_CONV;
         end
         S_CONV: begin
            eng_step = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            out_we = 1'b1;
            if (pend_full_q) begin
               consume  = 1'b1;
               eng_load = 1'b1;
               ld_addr  = pend_addr_q;
               ld_val   = pend_val_q;
               cnt_d    = '0;
               state_d  = S_CONV;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A store arriving while the engines are busy always wins the pending slot.
      pend_full_d = pend_full_q;
      pend_addr_d = pend_addr_q;
      pend_val_d  = pend_val_q;
      overrun_inc = 1'b0;
      if (acc && state_q != S_IDLE) begin
         pend_full_d = 1'b1;
         pend_addr_d = cap_addr;
         pend_val_d  = cap_val;
         overrun_inc = pend_full_q && !consume;
      end else if (consume) begin
         pend_full_d = 1'b0;
      end

      store_cnt_d   = (acc && store_cnt_q != '1) ? store_cnt_q + 1'b1 : store_cnt_q;
      overrun_cnt_d = (overrun_inc && overrun_cnt_q != '1) ? overrun_cnt_q + 1'b1 : overrun_cnt_q;
   end

   bin2bcd_seq #(.BITS(N), .DIGITS(ADDR_DIGITS)) u_addr_conv (
      .clk(clk), .reset(reset), .load(eng_load), .bin(ld_addr), .step(eng_step), .bcd(eng_addr_bcd)
   );

   bin2bcd_seq #(.BITS(N), .DIGITS(VAL_DIGITS)) u_val_conv (
      .clk(clk), .reset(reset), .load(eng_load), .bin(ld_val), .step(eng_step), .bcd(eng_val_bcd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: non-blocking assignments throughout, and the pending buffer is cleared like any other state.
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pend_full_q   <= 1'b0;
         pend_addr_q   <= '0;
         pend_val_q    <= '0;
         addr_bcd_q    <= '0;
         val_bcd_q     <= '0;
         upd_q         <= 1'b0;
         store_cnt_q   <= '0;
         overrun_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pend_full_q   <= pend_full_d;
         pend_addr_q   <= pend_addr_d;
         pend_val_q    <= pend_val_d;
         upd_q         <= out_we;
         store_cnt_q   <= store_cnt_d;
         overrun_cnt_q <= overrun_cnt_d;
         if (out_we) begin
            addr_bcd_q <= eng_addr_bcd;
            val_bcd_q  <= eng_val_bcd;
         end
      end
   end

   assign bus.addr_bcd    = addr_bcd_q;
   assign bus.val_bcd     = val_bcd_q;
   assign bus.upd_pulse   = upd_q;
   assign bus.busy        = state_q != S_IDLE;
   assign bus.pend_full   = pend_full_q;
   assign bus.store_cnt   = store_cnt_q;
   assign bus.overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_store_bcd_monitor.sv
// Scoreboard bench: stimulus pushes expected BCD results, per-DUT monitors pop them on upd_pulse.
module tb_store_bcd_monitor;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   store_bcd_monitor_if                 bus_a ();
   store_bcd_monitor_if                 bus_f ();
   store_bcd_monitor_if #(.CNT_W(4))    bus_c ();

   store_bcd_monitor                                     dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   store_bcd_monitor #(.FILTER_EN(1'b1), .WATCH_ADDR(96)) dut_f (.clk(clk), .reset(reset), .bus(bus_f));
   store_bcd_monitor #(.CNT_W(4))                        dut_c (.clk(clk), .reset(reset), .bus(bus_c));

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q_a[$], q_f[$], q_c[$];
   int   pulses_a = 0, pulses_f = 0, pulses_c = 0;
   logic prev_a = 1'b0, prev_f = 1'b0, prev_c = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] dec2(input int i);
      return 16'(((i / 10) << 4) | (i % 10));
   endfunction

   // Monitors: every upd_pulse must match the oldest expectation and never repeat on the next cycle.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (bus_a.upd_pulse) begin
         pulses_a++;
         check("a_upd_single", 32'(prev_a), 32'd0);
         check("a_upd_expected", 32'(q_a.size() > 0), 32'd1);
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_addr_bcd", 32'(bus_a.addr_bcd), 32'(e.a));
            check("a_val_bcd", 32'(bus_a.val_bcd), 32'(e.v));
         end
      end
      prev_a = bus_a.upd_pulse;
   end

   always @(negedge clk) begin : mon_f
      exp_t e;
      if (bus_f.upd_pulse) begin
         pulses_f++;
         check("f_upd_single", 32'(prev_f), 32'd0);
         check("f_upd_expected", 32'(q_f.size() > 0), 32'd1);
         if (q_f.size() > 0) begin
            e = q_f.pop_front();
            check("f_addr_bcd", 32'(bus_f.addr_bcd), 32'(e.a));
            check("f_val_bcd", 32'(bus_f.val_bcd), 32'(e.v));
         end
      end
      prev_f = bus_f.upd_pulse;
   end

   always @(negedge clk) begin : mon_c
      exp_t e;
      if (bus_c.upd_pulse) begin
         pulses_c++;
         check("c_upd_single", 32'(prev_c), 32'd0);
         check("c_upd_expected", 32'(q_c.size() > 0), 32'd1);
         if (q_c.size() > 0) begin
            e = q_c.pop_front();
            check("c_addr_bcd", 32'(bus_c.addr_bcd), 32'(e.a));
            check("c_val_bcd", 32'(bus_c.val_bcd), 32'(e.v));
         end
      end
      prev_c = bus_c.upd_pulse;
   end

   task automatic drive(input int which, input logic we, input logic [31:0] addr, input logic [31:0] val);
      case (which)
         0: begin bus_a.mem_write = we; bus_a.data_addr = addr; bus_a.write_data = val; end
         1: begin bus_f.mem_write = we; bus_f.data_addr = addr; bus_f.write_data = val; end
         default: begin bus_c.mem_write = we; bus_c.data_addr = addr; bus_c.write_data = val; end
      endcase
   endtask

   // Called at a negedge; returns at the negedge after the sampling edge.
   task automatic store(input int which, input logic [31:0] addr, input logic [31:0] val);
      drive(which, 1'b1, addr, val);
      @(negedge clk);
      drive(which, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int p0;
      reset = 1'b1;
      for (int w = 0; w < 3; w++) drive(w, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      check("rst_addr_bcd", 32'(bus_a.addr_bcd), 32'd0);
      check("rst_val_bcd", 32'(bus_a.val_bcd), 32'd0);
      check("rst_upd", 32'(bus_a.upd_pulse), 32'd0);
      check("rst_busy", 32'(bus_a.busy), 32'd0);
      check("rst_store_cnt", 32'(bus_a.store_cnt), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic conversion and exact latency.
      q_a.push_back('{a: 16'h0096, v: 16'h0025});
      store(0, 32'd96, 32'd25);
      repeat (10) @(negedge clk);
      check("t1_hold_addr", 32'(bus_a.addr_bcd), 32'd0);
      check("t1_busy", 32'(bus_a.busy), 32'd1);
      @(negedge clk);
      check("t1_addr_now", 32'(bus_a.addr_bcd), 32'h0096);
      check("t1_upd", 32'(bus_a.upd_pulse), 32'd1);
      check("t1_store_cnt", 32'(bus_a.store_cnt), 32'd1);
      @(negedge clk);
      check("t1_upd_low", 32'(bus_a.upd_pulse), 32'd0);
      check("t1_idle", 32'(bus_a.busy), 32'd0);

      // Range extremes.
      q_a.push_back('{a: 16'h1023, v: 16'h1023});
      store(0, 32'd1023, 32'd1023);
      repeat (14) @(negedge clk);
      check("t2_max_val", 32'(bus_a.val_bcd), 32'h1023);
      q_a.push_back('{a: 16'h0000, v: 16'h0000});
      store(0, 32'd0, 32'd0);
      repeat (14) @(negedge clk);
      check("t2_zero_addr", 32'(bus_a.addr_bcd), 32'h0000);

      // Back-to-back stores: the middle one is overwritten in the pending buffer.
      pulse_reset();
      p0 = pulses_a;
      q_a.push_back('{a: 16'h0001, v: 16'h0011});
      q_a.push_back('{a: 16'h0003, v: 16'h0033});
      drive(0, 1'b1, 32'd1, 32'd11);
      @(negedge clk);
      drive(0, 1'b1, 32'd2, 32'd22);
      @(negedge clk);
      drive(0, 1'b1, 32'd3, 32'd33);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0);
      check("t3_pend_full", 32'(bus_a.pend_full), 32'd1);
      check("t3_overrun_early", 32'(bus_a.overrun_cnt), 32'd1);
      repeat (25) @(negedge clk);
      check("t3_pulses", 32'(pulses_a - p0), 32'd2);
      check("t3_store_cnt", 32'(bus_a.store_cnt), 32'd3);
      check("t3_overrun_cnt", 32'(bus_a.overrun_cnt), 32'd1);
      check("t3_pend_empty", 32'(bus_a.pend_full), 32'd0);
      check("t3_idle", 32'(bus_a.busy), 32'd0);

      // Reset in the middle of a conversion clears everything at once and aborts it.
      store(0, 32'd5, 32'd6);
      repeat (4) @(negedge clk);
      check("t5_busy_before", 32'(bus_a.busy), 32'd1);
      reset = 1'b1;
      #1;
      check("t5_addr_cleared", 32'(bus_a.addr_bcd), 32'd0);
      check("t5_val_cleared", 32'(bus_a.val_bcd), 32'd0);
      check("t5_cnt_cleared", 32'(bus_a.store_cnt), 32'd0);
      check("t5_overrun_cleared", 32'(bus_a.overrun_cnt), 32'd0);
      check("t5_busy_cleared", 32'(bus_a.busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      p0 = pulses_a;
      repeat (20) @(negedge clk);
      check("t5_no_pulse", 32'(pulses_a - p0), 32'd0);
      check("t5_idle", 32'(bus_a.busy), 32'd0);
      check("t5_addr_still_zero", 32'(bus_a.addr_bcd), 32'd0);

      // Address filter.
      store(1, 32'd100, 32'd9);
      repeat (15) @(negedge clk);
      check("t4_filtered_cnt", 32'(bus_f.store_cnt), 32'd0);
      check("t4_filtered_pulses", 32'(pulses_f), 32'd0);
      check("t4_filtered_val", 32'(bus_f.val_bcd), 32'd0);
      q_f.push_back('{a: 16'h0096, v: 16'h0007});
      store(1, 32'd96, 32'd7);
      repeat (12) @(negedge clk);
      check("t4_match_cnt", 32'(bus_f.store_cnt), 32'd1);
      check("t4_match_pulses", 32'(pulses_f), 32'd1);

      // Narrow counters saturate.
      for (int i = 0; i < 20; i++) begin
         q_c.push_back('{a: dec2(i), v: dec2(i)});
         store(2, 32'(i), 32'(i));
         repeat (12) @(negedge clk);
         if (i == 14) check("t6_cnt_at_15", 32'(bus_c.store_cnt), 32'd15);
      end
      check("t6_cnt_saturated", 32'(bus_c.store_cnt), 32'd15);
      check("t6_no_overrun", 32'(bus_c.overrun_cnt), 32'd0);
      q_c.push_back('{a: 16'h0100, v: 16'h0000});
      q_c.push_back('{a: 16'h0110, v: 16'h0010});
      q_c.push_back('{a: 16'h0119, v: 16'h0019});
      for (int k = 0; k < 20; k++) begin
         drive(2, 1'b1, 32'(100 + k), 32'(k));
         @(negedge clk);
      end
      drive(2, 1'b0, 32'd0, 32'd0);
      repeat (40) @(negedge clk);
      check("t6_overrun_saturated", 32'(bus_c.overrun_cnt), 32'd15);
      check("t6_cnt_still_15", 32'(bus_c.store_cnt), 32'd15);

      for (int w = 0; w < 50 && (q_a.size() + q_f.size() + q_c.size()) != 0; w++) @(negedge clk);
      check("scoreboard_drained", 32'(q_a.size() + q_f.size() + q_c.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
